// File: rtl/alu_seq_param.sv
// Registered W-bit ALU with valid/ready handshakes on both sides and an iterative signed multiplier.
// Ops 000-110 produce a result on the accept edge; op 111 runs W shift-add steps, then a sign fix.
module alu_seq_param #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         zero
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic            neg;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic [W:0]      sum_w;
    logic [W:0]      dif_w;
    logic [W-1:0]    a_half;
    logic [W+2:0]    sum_x;
    logic [W+2:0]    m1;
    logic [W+2:0]    m2;
    logic [W-1:0]    res_c;
    logic [PW-1:0]   prod;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle opcodes evaluated straight from the operand inputs.
    always_comb begin
        sum_w  = {a[W-1], a} + {b[W-1], b};
        dif_w  = {a[W-1], a} - {b[W-1], b};
        a_half = {a[W-1], a[W-1:1]};
        sum_x  = {{2{sum_w[W]}}, sum_w};
        m1     = {{3{a_half[W-1]}}, a_half} + ({{3{b[W-1]}}, b} << 2);
        m2     = sum_x + (sum_x << 1);
        res_c  = '0;
        case (sel)
            3'b000:  res_c = sum_w[W:1];
            3'b001:  res_c = dif_w[W:1];
            3'b010:  res_c = a & b;
            3'b011:  res_c = a | b;
            3'b100:  res_c = a ^ b;
            3'b101:  res_c = m1[W+2:3];
            3'b110:  res_c = m2[W+2:3];
            default: res_c = '0;
        endcase
    end

    // Signed product from the magnitude accumulator.
    always_comb begin
        prod = neg ? (PW'(0) - acc) : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (sel == 3'b111) begin
                            mag_a     <= a[W-1] ? W'(~a + W'(1)) : a;
                            mag_b     <= b[W-1] ? W'(~b + W'(1)) : b;
                            neg       <= a[W-1] ^ b[W-1];
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= MUL;
                        end else begin
                            out       <= res_c;
                            zero      <= (res_c == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                MUL: begin
                    if (mag_b[cnt]) begin
                        acc <= acc + (PW'(mag_a) << cnt);
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    out       <= prod[PW-1:W];
                    zero      <= (prod[PW-1:W] == '0);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed and randomized checks of alu_seq_param (W=8) against an arithmetic reference model.
module tb_alu_seq_param;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       zero;

    int vectors = 0;
    int errors  = 0;

    alu_seq_param #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then arithmetic shift and keep the low 8 bits.
    function automatic logic [7:0] model(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
        int sx;
        int sy;
        int r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        case (s)
            3'd0:    r = (sx + sy) >>> 1;
            3'd1:    r = (sx - sy) >>> 1;
            3'd2:    r = int'(x & y);
            3'd3:    r = int'(x | y);
            3'd4:    r = int'(x ^ y);
            3'd5:    r = ((sx >>> 1) + 4 * sy) >>> 3;
            3'd6:    r = (3 * (sx + sy)) >>> 3;
            default: r = (sx * sy) >>> 8;
        endcase
        return 8'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one op from IDLE, count edges after the accept edge until out_valid.
    task automatic run_op(input string tag, input logic [2:0] s, input logic [7:0] x, input logic [7:0] y,
                          input int exp_lat, input logic [7:0] exp_out);
        int lat;
        sel = s; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " out"}, 32'(out), 32'(exp_out));
        check({tag, " zero"}, 32'(zero), 32'(exp_out == 8'h00));
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " retire valid"}, 32'(out_valid), 32'd0);
        check({tag, " retire ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] expq[$];
        logic [7:0] e;
        int accepted;
        int cyc;
        bit took;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sel = '0;
        @(posedge clk); @(posedge clk); #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out", 32'(out), 32'h00);
        check("reset zero", 32'(zero), 32'd0);
        rst = 1'b0;

        run_op("add", 3'b000, 8'd100, 8'd100, 0, 8'h64);
        retire("add");
        run_op("sub", 3'b001, 8'h80, 8'd127, 0, 8'h80);
        retire("sub");
        run_op("x3", 3'b110, 8'd50, 8'd30, 0, 8'h1E);
        retire("x3");
        run_op("mix", 3'b101, 8'hF9, 8'd3, 0, 8'h01);
        retire("mix");
        run_op("and", 3'b010, 8'h0F, 8'hF0, 0, 8'h00);
        retire("and");
        run_op("mul_min", 3'b111, 8'h80, 8'h80, 9, 8'h40);
        retire("mul_min");
        run_op("mul_neg", 3'b111, 8'hFD, 8'd5, 9, 8'hFF);
        retire("mul_neg");

        // Back-pressure hold, then retire and accept on the same edge.
        run_op("hold", 3'b011, 8'h12, 8'h21, 0, 8'h33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold out", 32'(out), 32'h33);
            check("hold in_ready", 32'(in_ready), 32'd0);
            check("hold valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        sel = 3'b100; a = 8'hFF; b = 8'h0F;
        #1;
        check("swap in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("swap out", 32'(out), 32'hF0);
        check("swap valid", 32'(out_valid), 32'd1);
        retire("swap");

        // Reset in the middle of a multiply.
        sel = 3'b111; a = 8'd7; b = 8'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out", 32'(out), 32'h00);
        repeat (12) @(posedge clk);
        #1;
        check("abort no result", 32'(out_valid), 32'd0);

        // Random stream with random back-pressure.
        accepted = 0;
        cyc = 0;
        while ((accepted < 200 || expq.size() > 0) && cyc < 20000) begin
            if (!in_valid && accepted < 200 && $urandom_range(0, 3) != 0) begin
                sel = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            took = 1'b0;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("rand spurious result", 32'(out_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("rand out", 32'(out), 32'(e));
                    check("rand zero", 32'(zero), 32'(e == 8'h00));
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(sel, a, b));
                accepted++;
                took = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (took) in_valid = 1'b0;
        end
        check("rand stream complete", 32'(accepted == 200 && expq.size() == 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
